alu_divider: RTL and testbench

Multi-cycle RV32M divide unit in the execute stage, beside the single-cycle ALU. It takes the same operand pair (A, B) that feeds the ALU, plus the funct3 low bits of an OP-opcode (0110011) instruction with funct7 = 0000001. It returns DIV/DIVU/REM/REMU results after a fixed iteration count. The pipeline stalls on `busy` and muxes `result` into the ALU result path when `done` pulses.

---
 rtl/alu_divider_pkg.sv | 40 ++++
 rtl/alu_divider_div_step.sv | 22 ++
 rtl/alu_divider.sv | 153 +++++++++++++++
 tb/tb_alu_divider.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_divider_pkg.sv
// Shared RV32M divide constants, operation encodings and FSM states.
// ALUControl uses the same encodings when decoding OP-opcode instructions.
package alu_divider_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    // The divider only sees funct3[1:0].
    localparam logic [1:0] OP_DIV  = FUNCT3_DIV[1:0];
    localparam logic [1:0] OP_DIVU = FUNCT3_DIVU[1:0];
    localparam logic [1:0] OP_REM  = FUNCT3_REM[1:0];
    localparam logic [1:0] OP_REMU = FUNCT3_REMU[1:0];

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CALC    = 2'd1,
        ST_FIX     = 2'd2,
        ST_SPECIAL = 2'd3
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic is_div_instr(input logic [6:0] opcode,
                                          input logic [6:0] funct7,
                                          input logic [2:0] funct3);
        return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV) && funct3[2];
    endfunction

endpackage

// File: rtl/alu_divider_div_step.sv
// One restoring radix-2 iteration: shift in the dividend MSB, compare, subtract.
module alu_divider_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic            dividend_msb_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            quot_bit_o
);

    logic [XLEN:0] trial;

    // NOTE: every output is assigned on every path, so no latch is inferred.
    always_comb begin
        trial      = {rem_i, dividend_msb_i};
        quot_bit_o = (trial >= {1'b0, divisor_i});
        // trial - divisor < divisor here, so the low XLEN bits are exact.
        rem_o      = quot_bit_o ? (trial[XLEN-1:0] - divisor_i) : trial[XLEN-1:0];
    end

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit beside the execute-stage ALU.
// Magnitudes are divided unsigned; signs are restored in FIX.
module alu_divider
    import alu_divider_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    localparam int                CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]   ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]   SIGN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e        state_q,  state_d;
    logic [1:0]        op_q,     op_d;
    logic [XLEN-1:0]   dq_q,     dq_d;
    logic [XLEN-1:0]   rem_q,    rem_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q,   done_d;

    logic              req_signed;
    logic              div_by_zero;
    logic              overflow;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic [XLEN-1:0]   step_rem;
    logic              step_bit;

    // dq_q holds the dividend on entry; quotient bits shift in from the LSB.
    alu_divider_div_step #(.XLEN(XLEN)) div_step (
        .rem_i          (rem_q),
        .dividend_msb_i (dq_q[XLEN-1]),
        .divisor_i      (divisor_q),
        .rem_o          (step_rem),
        .quot_bit_o     (step_bit)
    );

    always_comb begin
        req_signed  = op_is_signed(op);
        div_by_zero = (B == '0);
        overflow    = req_signed && (A == SIGN_MIN) && (B == ALL_ONES);
        abs_a       = (req_signed && A[XLEN-1]) ? -A : A;
        abs_b       = (req_signed && B[XLEN-1]) ? -B : B;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        dq_d      = dq_q;
        rem_d     = rem_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        result_d  = result_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !kill) begin
                    op_d = op;
                    if (div_by_zero || overflow) begin
                        // The special value is parked in dq_q for SPECIAL to publish.
                        state_d = ST_SPECIAL;
                        if (op_is_rem(op)) dq_d = div_by_zero ? A : '0;
                        else               dq_d = div_by_zero ? ALL_ONES : SIGN_MIN;
                    end else begin
                        state_d   = ST_CALC;
                        dq_d      = abs_a;
                        divisor_d = abs_b;
                        sign_a_d  = req_signed & A[XLEN-1];
                        sign_b_d  = req_signed & B[XLEN-1];
                        rem_d     = '0;
                        cnt_d     = CNT_INIT;
                    end
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                dq_d  = {dq_q[XLEN-2:0], step_bit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (op_is_rem(op_q)) result_d = sign_a_q ? -rem_q : rem_q;
                else                 result_d = (sign_a_q ^ sign_b_q) ? -dq_q : dq_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_SPECIAL: begin
                result_d = dq_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A flush abandons the operation without publishing anything.
        if (kill && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            result_d = result_q;
            done_d   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            dq_q      <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            dq_q      <= dq_d;
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;

endmodule

// File: tb/tb_alu_divider.sv
// Directed bench for alu_divider: hand-computed results, latencies, kill and reset.
module tb_alu_divider;
    import alu_divider_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    alu_divider #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .kill   (kill),
        .op     (op_i),
        .A      (a_i),
        .B      (b_i),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds start for cycle 0; returns in cycle 1.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        op_i  = op;
        a_i   = a;
        b_i   = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 100) begin
            step();
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_cyc);
        int cyc;
        launch(op, a, b);
        wait_done(cyc);
        check({tag, "_cycle"}, cyc, exp_cyc);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check(tag, result, exp);
    endtask

    initial begin
        int n_done;
        int done_cyc;
        logic [31:0] got;

        rst_n = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        op_i  = OP_DIVU;
        a_i   = '0;
        b_i   = '0;
        repeat (3) step();
        rst_n = 1'b1;
        check("reset_result", result, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);

        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
        run_op("div_m20_3",  OP_DIV,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34);
        run_op("rem_m20_3",  OP_REM,  32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34);
        run_op("div_20_m3",  OP_DIV,  32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 34);
        run_op("rem_20_m3",  OP_REM,  32'd20, 32'hFFFF_FFFD, 32'd2, 34);
        run_op("div_m20_m3", OP_DIV,  32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'd6, 34);
        run_op("rem_m20_m3", OP_REM,  32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 34);
        run_op("divu_max_16", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 34);
        run_op("remu_max_16", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 34);
        run_op("divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
        run_op("remu_min_m1", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);

        run_op("divu_by0", OP_DIVU, 32'h3E8, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("remu_by0", OP_REMU, 32'h3E8, 32'd0, 32'h3E8, 2);
        run_op("div_m5_by0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 2);
        run_op("rem_m5_by0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 2);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);

        // Stray starts at cycles 5 and 20 with different operands must be ignored.
        launch(OP_DIVU, 32'd100, 32'd7);
        n_done   = 0;
        done_cyc = 0;
        got      = '0;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                n_done++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    got      = result;
                end
            end
            start = (c == 5 || c == 20);
            op_i  = OP_REMU;
            a_i   = 32'd999;
            b_i   = 32'd5;
            step();
        end
        start = 1'b0;
        check("busy_start_done_count", n_done, 32'd1);
        check("busy_start_done_cycle", done_cyc, 32'd34);
        check("busy_start_result", got, 32'd14);

        // Start coincident with done is accepted and completes 34 cycles later.
        launch(OP_DIVU, 32'd100, 32'd7);
        wait_done(done_cyc);
        check("b2b_first_result", result, 32'd14);
        run_op("b2b_second", OP_REMU, 32'd1000, 32'd7, 32'd6, 34);

        // Kill in cycle 10: idle in cycle 11, no done, result keeps 6.
        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (9) step();
        kill = 1'b1;
        step();
        kill = 1'b0;
        check("kill_busy", {31'd0, busy}, 32'd0);
        check("kill_done", {31'd0, done}, 32'd0);
        check("kill_result", result, 32'd6);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) n_done++;
            step();
        end
        check("kill_no_done", n_done, 32'd0);
        check("kill_result_held", result, 32'd6);

        // Kill and start together in IDLE: start is dropped.
        op_i  = OP_DIVU;
        a_i   = 32'd100;
        b_i   = 32'd7;
        start = 1'b1;
        kill  = 1'b1;
        step();
        start = 1'b0;
        kill  = 1'b0;
        check("kill_start_busy", {31'd0, busy}, 32'd0);
        step();
        check("kill_start_done", {31'd0, done}, 32'd0);

        // Reset in cycle 15 mid-operation clears everything.
        launch(OP_DIVU, 32'd100, 32'd7);
        repeat (14) step();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        step();
        check("midop_reset_result", result, 32'd0);
        check("midop_reset_busy", {31'd0, busy}, 32'd0);
        check("midop_reset_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;

        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
        run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
